sdhost_cmd: RTL and testbench

SDHOST_CMD -- requirements
Module: sdhost_cmd

---
 rtl/sdhost_pkg.sv | 25 ++
 rtl/sdcrc7.sv | 21 ++
 rtl/sdhost_cmd.sv | 161 ++++++++++++++++
 tb/tb_sdhost_cmd.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sdhost_pkg.sv
// Shared constants and types for the SD host command-line engine.
package sdhost_pkg;

  localparam int unsigned FRAME_LEN  = 48;   // command / R1 / R3 frame bits
  localparam int unsigned R2_LEN     = 136;  // R2 (CID/CSD) frame bits
  localparam int unsigned NCC        = 8;    // idle strobes between commands
  localparam int unsigned TURNAROUND = 2;    // strobes ignored after end bit
  localparam int unsigned CRC_BITS   = 40;   // frame bits covered by CRC7

  typedef enum logic [1:0] {
    RT_NONE = 2'd0,
    RT_R1   = 2'd1,
    RT_R2   = 2'd2,
    RT_R3   = 2'd3
  } rtype_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_GAP
  } state_t;

endpackage

// File: rtl/sdcrc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, initial value 0.
module sdcrc7 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic fb;
  assign fb = i_bit ^ o_crc[6];

  // Shift one bit per enable; clear takes priority.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      o_crc <= '0;
    else if (i_clear) o_crc <= '0;
    else if (i_en)    o_crc <= {o_crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  end

endmodule

// File: rtl/sdhost_cmd.sv
// SD host CMD-line engine: sends a 48-bit command, receives R1/R2/R3 responses.
module sdhost_cmd
  import sdhost_pkg::*;
#(
  parameter bit          OPT_R2    = 1'b1,
  parameter int unsigned LGTIMEOUT = 6
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_ckstb,
  input  logic         i_request,
  input  logic [1:0]   i_rtype,
  input  logic [5:0]   i_cmd,
  input  logic [31:0]  i_arg,
  output logic         o_busy,
  output logic         o_cmd_en,
  output logic         o_cmd,
  input  logic         i_cmd_line,
  output logic         o_rsp_valid,
  output logic [5:0]   o_rsp_cmd,
  output logic [119:0] o_rsp_data,
  output logic         o_crc_err,
  output logic         o_timeout
);

  localparam int unsigned CW = (LGTIMEOUT > 6) ? LGTIMEOUT + 2 : 8;
  localparam logic [CW-1:0] TX_LAST   = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CRC_START = CW'(CRC_BITS);
  localparam logic [CW-1:0] TURN      = CW'(TURNAROUND);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TURNAROUND + (1 << LGTIMEOUT) - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(NCC - 1);
  localparam logic [CW-1:0] R1_LAST   = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] R2_LAST   = CW'(R2_LEN - 1);
  localparam logic [CW-1:0] R2_PAY_LO = CW'(8);
  localparam logic [CW-1:0] R2_PAY_HI = CW'(R2_LEN - 9);
  localparam logic [CW-1:0] ONE       = CW'(1);

  state_t         state, state_nx;
  rtype_t         rtype;
  logic [CW-1:0]  cnt, rx_last, crc_idx;
  logic [39:0]    tx_sr;
  logic [125:0]   rx_sr;
  logic [6:0]     rx_fld, tx_crc, rx_crc;
  logic           tbit, accept, is_r2, tx_bit, tx_crc_en, rx_crc_en;

  assign accept  = i_request && (state == ST_IDLE);
  assign o_busy  = (state != ST_IDLE);
  assign is_r2   = OPT_R2 && (rtype == RT_R2);
  assign rx_last = is_r2 ? R2_LAST : R1_LAST;
  assign crc_idx = TX_LAST - ONE - cnt;

  sdcrc7 u_tx_crc (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(accept),
    .i_en(tx_crc_en), .i_bit(tx_sr[39]), .o_crc(tx_crc)
  );

  sdcrc7 u_rx_crc (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(accept),
    .i_en(rx_crc_en), .i_bit(i_cmd_line), .o_crc(rx_crc)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Next-state decode; all bit-level transitions wait for a strobe.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (i_request) state_nx = ST_TX;
      ST_TX:   if (i_ckstb && cnt == TX_LAST)
                 state_nx = (rtype == RT_NONE) ? ST_GAP : ST_WAIT;
      ST_WAIT: if (i_ckstb && cnt >= TURN) begin
                 if (!i_cmd_line)            state_nx = ST_RX;
                 else if (cnt == WAIT_LAST)  state_nx = ST_GAP;
               end
      ST_RX:   if (i_ckstb && cnt == rx_last) state_nx = ST_GAP;
      ST_GAP:  if (i_ckstb && cnt == GAP_LAST) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outgoing bit select and CRC enables.
  // The R1 start bit is 0 into an all-zero CRC, so starting the RX CRC at
  // bit 1 gives the same result as covering bits 0..39.
  always_comb begin
    tx_bit    = 1'b1;
    tx_crc_en = 1'b0;
    rx_crc_en = 1'b0;
    if (cnt < CRC_START)  tx_bit = tx_sr[39];
    else if (cnt < TX_LAST) tx_bit = tx_crc[crc_idx[2:0]];
    if (state == ST_TX && i_ckstb && cnt < CRC_START) tx_crc_en = 1'b1;
    if (state == ST_RX && i_ckstb) begin
      if (is_r2) rx_crc_en = (cnt >= R2_PAY_LO) && (cnt <= R2_PAY_HI);
      else       rx_crc_en = (cnt < CRC_START);
    end
  end

  // Datapath: frame shifting, line drive, response capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rtype       <= RT_NONE;
      cnt         <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rx_fld      <= '0;
      tbit        <= 1'b0;
      o_cmd_en    <= 1'b0;
      o_cmd       <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_cmd   <= '0;
      o_rsp_data  <= '0;
      o_crc_err   <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      if (accept) begin
        rtype <= rtype_t'(i_rtype);
        tx_sr <= {2'b01, i_cmd, i_arg};
      end
      if (state_nx != state)                 cnt <= (state_nx == ST_RX) ? ONE : '0;
      else if (i_ckstb && state != ST_IDLE)  cnt <= cnt + ONE;
      if (i_ckstb) begin
        if (state == ST_TX) begin
          o_cmd_en <= 1'b1;
          o_cmd    <= tx_bit;
          if (cnt < CRC_START) tx_sr <= {tx_sr[38:0], 1'b0};
        end else begin
          o_cmd_en <= 1'b0;
          o_cmd    <= 1'b1;
        end
        if (state == ST_WAIT && state_nx == ST_GAP) begin
          o_rsp_valid <= 1'b1;
          o_timeout   <= 1'b1;
          o_crc_err   <= 1'b0;
        end
        if (state == ST_RX) begin
          if (cnt == ONE)                   tbit   <= i_cmd_line;
          else if (cnt <= rx_last - CW'(8)) rx_sr  <= {rx_sr[124:0], i_cmd_line};
          else if (cnt < rx_last)           rx_fld <= {rx_fld[5:0], i_cmd_line};
          else begin
            o_rsp_valid <= 1'b1;
            o_timeout   <= 1'b0;
            o_crc_err   <= tbit | ~i_cmd_line |
                           ((rtype != RT_R3) && (rx_fld != rx_crc));
            if (is_r2) begin
              o_rsp_cmd  <= rx_sr[125:120];
              o_rsp_data <= rx_sr[119:0];
            end else begin
              o_rsp_cmd  <= rx_sr[37:32];
              o_rsp_data <= {88'b0, rx_sr[31:0]};
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sdhost_cmd.sv
// Directed self-checking bench for sdhost_cmd.
module tb_sdhost_cmd;

  logic         clk, rst, ckstb, req, cmd_en, cmd_o, line, rsp_valid, crc_err, tmo, busy;
  logic [1:0]   rtype;
  logic [5:0]   cmd, rsp_cmd;
  logic [31:0]  arg;
  logic [119:0] rsp_data;

  sdhost_cmd #(.OPT_R2(1'b1), .LGTIMEOUT(6)) dut (
    .i_clk(clk), .i_reset(rst), .i_ckstb(ckstb), .i_request(req),
    .i_rtype(rtype), .i_cmd(cmd), .i_arg(arg), .o_busy(busy),
    .o_cmd_en(cmd_en), .o_cmd(cmd_o), .i_cmd_line(line),
    .o_rsp_valid(rsp_valid), .o_rsp_cmd(rsp_cmd), .o_rsp_data(rsp_data),
    .o_crc_err(crc_err), .o_timeout(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int duty = 1, cur_j, nvalid, vj, fallj, en_bad, hold_bad;
  logic         busy1, rerr, rto;
  logic [5:0]   rcmd;
  logic [119:0] rdata;
  logic [47:0]  tx;
  longint       t_first, t_fall;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7_120(input logic [119:0] d);
    logic [6:0] c = '0;
    logic fb;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic sample();
    if (rsp_valid) begin
      nvalid++; vj = cur_j;
      rcmd = rsp_cmd; rdata = rsp_data; rerr = crc_err; rto = tmo;
    end
  endtask

  // One bit-time: a single strobe cycle followed by duty-1 idle cycles.
  task automatic bit_time();
    logic c0, e0;
    ckstb = 1'b1; @(posedge clk); #1; ckstb = 1'b0; sample();
    c0 = cmd_o; e0 = cmd_en;
    for (int i = 1; i < duty; i++) begin
      @(posedge clk); #1; sample();
      if (cmd_o !== c0 || cmd_en !== e0) hold_bad++;
    end
  endtask

  task automatic xact(input logic [5:0] c, input logic [31:0] a, input logic [1:0] rt,
                      input logic [135:0] rsp, input int rlen, input int d, input bit poke);
    nvalid = 0; vj = -1; fallj = -1; en_bad = 0; hold_bad = 0; tx = '0;
    cmd = c; arg = a; rtype = rt; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    busy1 = busy;
    cur_j = 0;
    for (int k = 0; k < 48; k++) begin
      if (poke && k == 10) begin req = 1'b1; cmd = 6'h3F; end
      bit_time();
      if (k == 0) t_first = $time;
      if (poke && k == 10) begin req = 1'b0; cmd = c; end
      tx = {tx[46:0], cmd_o};
      if (!cmd_en) en_bad++;
    end
    for (int j = 1; j <= 400; j++) begin
      cur_j = j;
      if (rlen > 0 && j >= d && j < d + rlen) line = rsp[135 - (j - d)];
      else line = 1'b1;
      bit_time();
      if (j == 1 && cmd_en) en_bad++;
      if (!busy) begin fallj = j; t_fall = $time; break; end
    end
    line = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [119:0] cid;
    logic [135:0] r2;
    rst = 1'b1; ckstb = 1'b0; req = 1'b0; rtype = 2'd0; cmd = '0; arg = '0; line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);       chk("rst_cmd_en", cmd_en, 0);
    chk("rst_cmd", cmd_o, 1);       chk("rst_valid", rsp_valid, 0);
    chk("rst_crc_err", crc_err, 0); chk("rst_timeout", tmo, 0);
    chk("rst_rsp_cmd", rsp_cmd, 0); chk("rst_rsp_data", rsp_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // CMD0, no response; a request raised mid-frame must be ignored.
    xact(6'd0, 32'h0, 2'd0, '0, 0, 0, 1'b1);
    chk("cmd0_tx", tx, 48'h400000000095);
    chk("cmd0_busy_rise", busy1, 1);
    chk("cmd0_cmd_en", en_bad, 0);
    chk("cmd0_no_valid", nvalid, 0);
    chk("cmd0_busy_fall", fallj, 8);
    chk("cmd0_no_requeue", busy, 0);

    // CMD8 with R7-style R1 reply starting on the first sampled strobe.
    xact(6'd8, 32'h1AA, 2'd1, {48'h08000001AA13, 88'h0}, 48, 3, 1'b0);
    chk("cmd8_tx", tx, 48'h48000001AA87);
    chk("cmd8_nvalid", nvalid, 1);
    chk("cmd8_valid_at", vj, 50);
    chk("cmd8_rsp_cmd", rcmd, 6'd8);
    chk("cmd8_rsp_data", rdata, 120'h1AA);
    chk("cmd8_crc_err", rerr, 0);
    chk("cmd8_timeout", rto, 0);
    chk("cmd8_busy_fall", fallj, 58);
    chk("cmd8_hold_data", rsp_data, 120'h1AA);
    chk("cmd8_t_span", t_fall - t_first, 1050);

    // CMD55, good reply then one flipped payload bit.
    xact(6'd55, 32'h0, 2'd1, {48'h370000012083, 88'h0}, 48, 5, 1'b0);
    chk("cmd55_tx", tx, 48'h770000000065);
    chk("cmd55_rsp_data", rdata, 120'h120);
    chk("cmd55_crc_err", rerr, 0);
    chk("cmd55_valid_at", vj, 52);
    xact(6'd55, 32'h0, 2'd1, {48'h370000013083, 88'h0}, 48, 5, 1'b0);
    chk("cmd55f_crc_err", rerr, 1);
    chk("cmd55f_rsp_data", rdata, 120'h130);

    // Response timeout with the line held high.
    xact(6'd55, 32'h0, 2'd1, '0, 0, 0, 1'b0);
    chk("tmo_nvalid", nvalid, 1);
    chk("tmo_valid_at", vj, 66);
    chk("tmo_flag", rto, 1);
    chk("tmo_crc_err", rerr, 0);
    chk("tmo_busy_fall", fallj, 74);

    // ACMD41 with R3 reply: CRC field is all ones and must not be checked.
    xact(6'd41, 32'h40FF8000, 2'd3, {48'h3F80FF8000FF, 88'h0}, 48, 4, 1'b0);
    chk("r3_rsp_cmd", rcmd, 6'h3F);
    chk("r3_rsp_data", rdata, 120'h80FF8000);
    chk("r3_crc_err", rerr, 0);
    chk("r3_timeout", rto, 0);

    // CMD2 with 136-bit CID reply.
    cid = 120'h035344534430333280123456780142;
    r2 = {2'b00, 6'h3F, cid, crc7_120(cid), 1'b1};
    xact(6'd2, 32'h0, 2'd2, r2, 136, 5, 1'b0);
    chk("cmd2_tx", tx, 48'h42000000004D);
    chk("r2_rsp_cmd", rcmd, 6'h3F);
    chk("r2_rsp_data", rdata, cid);
    chk("r2_crc_err", rerr, 0);
    chk("r2_valid_at", vj, 140);
    chk("r2_busy_fall", fallj, 148);

    // CMD8 again at 1-in-4 strobe duty.
    duty = 4;
    xact(6'd8, 32'h1AA, 2'd1, {48'h08000001AA13, 88'h0}, 48, 3, 1'b0);
    chk("d4_tx", tx, 48'h48000001AA87);
    chk("d4_nvalid", nvalid, 1);
    chk("d4_valid_at", vj, 50);
    chk("d4_rsp_data", rdata, 120'h1AA);
    chk("d4_crc_err", rerr, 0);
    chk("d4_hold", hold_bad, 0);
    chk("d4_busy_fall", fallj, 58);
    chk("d4_t_span", t_fall - t_first, 4200);
    duty = 1;

    // Reset at frame bit 20.
    cmd = 6'd0; arg = 32'h0; rtype = 2'd0; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    for (int k = 0; k <= 20; k++) bit_time();
    chk("mid_pre_en", cmd_en, 1);
    #2; rst = 1'b1; #1;
    chk("mid_rst_en", cmd_en, 0);
    chk("mid_rst_cmd", cmd_o, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", rsp_data, 0);
    @(posedge clk); #1; rst = 1'b0; nvalid = 0;
    repeat (20) bit_time();
    chk("mid_no_valid", nvalid, 0);
    chk("mid_idle", busy, 0);
    xact(6'd8, 32'h1AA, 2'd1, {48'h08000001AA13, 88'h0}, 48, 3, 1'b0);
    chk("post_tx", tx, 48'h48000001AA87);
    chk("post_rsp_data", rdata, 120'h1AA);
    chk("post_crc_err", rerr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
